// File: rtl/ann_seq_pkg.sv
// Shared constants and FSM state encoding for the training-data sequencer.
package ann_seq_pkg;

  localparam int DEFAULT_ADDR_W  = 8;
  localparam int DEFAULT_EPOCH_W = 16;
  localparam int READ_LATENCY    = 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    RUN  = 3'd2,
    RD   = 3'd3,
    VLD  = 3'd4,
    DONE = 3'd5
  } seq_state_e;

endpackage

// File: rtl/train_data_sequencer_wrap_counter.sv
// Modulo-MODULUS up-counter with synchronous clear and a same-cycle wrap pulse.
module wrap_counter #(
  parameter int MODULUS = 4,
  parameter int W       = 8
) (
  input  logic         clk,
  input  logic         res,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  assign wrap = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (res || clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/train_data_sequencer.sv
// Sequences training-memory reads per NN-core sample request, counting epochs.
// Define EPOCH_LIMIT_EN to stop after NUM_EPOCHS epochs (DONE / train_done).
module train_data_sequencer
  import ann_seq_pkg::*;
#(
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int NUM_SAMPLES = 4,
  parameter int EPOCH_W     = DEFAULT_EPOCH_W,
  parameter int NUM_EPOCHS  = 1000
) (
  input  logic               clk,
  input  logic               res,
  input  logic               din,
  input  logic               select_initial,
  input  logic               sample_req,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic               sample_valid,
  output logic               sample_last,
  output logic [EPOCH_W-1:0] epoch_cnt,
  output logic               param_init,
  output logic               train_done,
  output seq_state_e         state
);

  // Handshake: a sample_req pulse is accepted only in RUN with din=1; the read
  // then occupies RD for one cycle and sample_valid follows exactly one cycle
  // later in VLD. Requests arriving anywhere else are dropped, never queued.

`ifdef EPOCH_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif
  localparam logic [EPOCH_W-1:0] EPOCH_LIMIT = EPOCH_W'(NUM_EPOCHS);
  localparam logic [ADDR_W-1:0]  LAST_ADDR   = ADDR_W'(NUM_SAMPLES - 1);

  seq_state_e        next_state;
  logic [ADDR_W-1:0] index;
  logic              idx_wrap;
  logic              idx_clr;
  logic              limit_stop;

  assign idx_clr    = (next_state == INIT);
  assign limit_stop = LIMIT_EN && (epoch_cnt == EPOCH_LIMIT);

  wrap_counter #(
    .MODULUS (NUM_SAMPLES),
    .W       (ADDR_W)
  ) u_index (
    .clk   (clk),
    .res   (res),
    .clr   (idx_clr),
    .en    (state == RD),
    .count (index),
    .wrap  (idx_wrap)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (select_initial) next_state = INIT;
        else if (din)       next_state = RUN;
      end
      INIT: next_state = din ? RUN : IDLE;
      RUN: begin
        if (select_initial)          next_state = INIT;
        else if (sample_req && din)  next_state = RD;
      end
      RD:  next_state = VLD;
      // epoch_cnt already reflects the wrap taken on the RD->VLD edge
      VLD: next_state = (sample_last && limit_stop) ? DONE : RUN;
      DONE: next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res || idx_clr) begin
      epoch_cnt <= '0;
    end else if (idx_wrap) begin
      epoch_cnt <= epoch_cnt + 1'b1;
    end
  end

  // Address is captured on entry to RD and then held, so it never moves mid-read.
  always_ff @(posedge clk) begin
    if (res) begin
      rd_addr <= '0;
    end else if (next_state == RD) begin
      rd_addr <= index;
    end
  end

  assign rd_en        = (state == RD);
  assign sample_valid = (state == VLD);
  assign sample_last  = sample_valid && (rd_addr == LAST_ADDR);
  assign param_init   = (state == INIT);

`ifdef EPOCH_LIMIT_EN
  logic done_q;
  always_ff @(posedge clk) begin
    if (res) begin
      done_q <= 1'b0;
    end else if (next_state == DONE) begin
      done_q <= 1'b1;
    end
  end
  assign train_done = done_q;
`else
  assign train_done = 1'b0;
`endif

endmodule

// File: tb/tb_train_data_sequencer.sv
// Table-driven bench for train_data_sequencer (NUM_SAMPLES=4, NUM_EPOCHS=3).
module tb_train_data_sequencer;
  import ann_seq_pkg::*;

  localparam int ADDR_W      = 8;
  localparam int NUM_SAMPLES = 4;
  localparam int EPOCH_W     = 16;
  localparam int NUM_EPOCHS  = 3;
`ifdef EPOCH_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic               clk;
  logic               res;
  logic               din;
  logic               select_initial;
  logic               sample_req;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic               sample_valid;
  logic               sample_last;
  logic [EPOCH_W-1:0] epoch_cnt;
  logic               param_init;
  logic               train_done;
  seq_state_e         state;

  train_data_sequencer #(
    .ADDR_W      (ADDR_W),
    .NUM_SAMPLES (NUM_SAMPLES),
    .EPOCH_W     (EPOCH_W),
    .NUM_EPOCHS  (NUM_EPOCHS)
  ) dut (
    .clk            (clk),
    .res            (res),
    .din            (din),
    .select_initial (select_initial),
    .sample_req     (sample_req),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .sample_valid   (sample_valid),
    .sample_last    (sample_last),
    .epoch_cnt      (epoch_cnt),
    .param_init     (param_init),
    .train_done     (train_done),
    .state          (state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string              name;
    logic               res, din, sel, req;
    seq_state_e         st;
    logic               rd_en;
    logic [ADDR_W-1:0]  addr;
    logic               vld, last;
    logic [EPOCH_W-1:0] epoch;
    logic               pinit, done;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(string name, bit r, bit d, bit s, bit q, seq_state_e st,
                              bit re, int addr, bit v, bit l, int ep, bit pi, bit dn);
    vec_t x;
    x.name = name; x.res = r; x.din = d; x.sel = s; x.req = q; x.st = st;
    x.rd_en = re; x.addr = ADDR_W'(addr); x.vld = v; x.last = l;
    x.epoch = EPOCH_W'(ep); x.pinit = pi; x.done = dn;
    return x;
  endfunction

  // driver: inputs change on negedge, outputs checked 1 time unit after posedge
  task automatic apply(input vec_t v);
    @(negedge clk);
    res = v.res; din = v.din; select_initial = v.sel; sample_req = v.req;
    @(posedge clk);
    #1;
    n_vec++;
    if (state !== v.st || rd_en !== v.rd_en || rd_addr !== v.addr ||
        sample_valid !== v.vld || sample_last !== v.last || epoch_cnt !== v.epoch ||
        param_init !== v.pinit || train_done !== v.done) begin
      n_fail++;
      $display("FAIL %s: got st=%0d rd_en=%0b addr=%0d vld=%0b last=%0b epoch=%0d pinit=%0b done=%0b; want st=%0d rd_en=%0b addr=%0d vld=%0b last=%0b epoch=%0d pinit=%0b done=%0b",
               v.name, state, rd_en, rd_addr, sample_valid, sample_last, epoch_cnt,
               param_init, train_done, v.st, v.rd_en, v.addr, v.vld, v.last, v.epoch,
               v.pinit, v.done);
    end
  endtask

  initial begin
    res = 1'b1; din = 1'b0; select_initial = 1'b0; sample_req = 1'b0;

    //                 name            res din sel req  state rd  addr vld last ep pi dn
    vecs.push_back(mk("reset",          1, 0, 0, 0,  IDLE, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("idle_hold",      0, 0, 0, 0,  IDLE, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("init_pulse",     0, 1, 1, 0,  INIT, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("init_to_run",    0, 1, 0, 0,  RUN,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("rd0",            0, 1, 0, 1,  RD,   1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("vld0_req_drop",  0, 1, 0, 1,  VLD,  0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("run_after0",     0, 1, 0, 0,  RUN,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("req_din0_drop",  0, 0, 0, 1,  RUN,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("rd1_resume",     0, 1, 0, 1,  RD,   1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("vld1",           0, 1, 0, 0,  VLD,  0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("run_after1",     0, 1, 0, 0,  RUN,  0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("rd2",            0, 1, 0, 1,  RD,   1, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk("vld2",           0, 1, 0, 0,  VLD,  0, 2, 1, 0, 0, 0, 0));
    vecs.push_back(mk("run_after2",     0, 1, 0, 0,  RUN,  0, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk("rd3",            0, 1, 0, 1,  RD,   1, 3, 0, 0, 0, 0, 0));
    vecs.push_back(mk("vld3_last",      0, 1, 0, 0,  VLD,  0, 3, 1, 1, 1, 0, 0));
    vecs.push_back(mk("run_epoch1",     0, 1, 0, 0,  RUN,  0, 3, 0, 0, 1, 0, 0));
    vecs.push_back(mk("sel_in_run",     0, 1, 1, 1,  INIT, 0, 3, 0, 0, 0, 1, 0));
    vecs.push_back(mk("init_din0_idle", 0, 0, 0, 0,  IDLE, 0, 3, 0, 0, 0, 0, 0));
    vecs.push_back(mk("idle_req_drop",  0, 0, 0, 1,  IDLE, 0, 3, 0, 0, 0, 0, 0));
    vecs.push_back(mk("idle_to_run",    0, 1, 0, 0,  RUN,  0, 3, 0, 0, 0, 0, 0));
    vecs.push_back(mk("rd_after_clear", 0, 1, 0, 1,  RD,   1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("reset_in_rd",    1, 1, 0, 0,  IDLE, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("no_vld_post_rst",0, 0, 0, 0,  IDLE, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("run_again",      0, 1, 0, 0,  RUN,  0, 0, 0, 0, 0, 0, 0));

    // three full epochs of spaced requests
    for (int i = 0; i < 3 * NUM_SAMPLES; i++) begin
      int  a;
      int  ep_rd;
      int  ep_vld;
      bit  stop;
      a      = i % NUM_SAMPLES;
      ep_rd  = i / NUM_SAMPLES;
      ep_vld = (i + 1) / NUM_SAMPLES;
      stop   = LIMIT && (i == 3 * NUM_SAMPLES - 1);
      vecs.push_back(mk($sformatf("ep_rd%0d", i),  0, 1, 0, 1, RD,  1, a, 0, 0, ep_rd, 0, 0));
      vecs.push_back(mk($sformatf("ep_vld%0d", i), 0, 1, 0, 0, VLD, 0, a, 1,
                        (a == NUM_SAMPLES - 1), ep_vld, 0, 0));
      vecs.push_back(mk($sformatf("ep_run%0d", i), 0, 1, 0, 0, stop ? DONE : RUN,
                        0, a, 0, 0, ep_vld, 0, stop));
    end

    if (LIMIT) begin
      vecs.push_back(mk("req13_done",   0, 1, 0, 1, DONE, 0, 3, 0, 0, 3, 0, 1));
      vecs.push_back(mk("done_sel_ign", 0, 1, 1, 1, DONE, 0, 3, 0, 0, 3, 0, 1));
    end else begin
      vecs.push_back(mk("req13_rd",     0, 1, 0, 1, RD,   1, 0, 0, 0, 3, 0, 0));
      vecs.push_back(mk("req13_vld",    0, 1, 0, 1, VLD,  0, 0, 1, 0, 3, 0, 0));
    end
    vecs.push_back(mk("final_reset",    1, 0, 0, 0, IDLE, 0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[k]) apply(vecs[k]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/train_data_sequencer.md
TRAIN_DATA_SEQUENCER -- requirements
Module: train_data_sequencer

Interface
REQ-001 Parameter ADDR_W, 8, training-memory address width.
REQ-002 Parameter NUM_SAMPLES, 4, samples per epoch, range 1..2**ADDR_W.
REQ-003 Parameter EPOCH_W, 16, epoch counter width.
REQ-004 Parameter NUM_EPOCHS, 1000, epochs before stop, range 1..2**EPOCH_W-1; used only with EPOCH_LIMIT_EN.
REQ-005 Single clock and reset: the block SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  system clock, all flops on posedge.
REQ-007 res  input  1  synchronous active-high reset.
REQ-008 din  input  1  memory read enable from the din/select generator; 1 = reads permitted.
REQ-009 select_initial  input  1  initial-parameter select; high for one cycle after reset release.
REQ-010 sample_req  input  1  one-cycle pulse from the NN core requesting the next sample.
REQ-011 rd_en  output  1  training-memory read strobe.
REQ-012 rd_addr  output  ADDR_W  training-memory read address.
REQ-013 sample_valid  output  1  memory data valid, one cycle after rd_en.
REQ-014 sample_last  output  1  qualifies sample_valid: last sample of epoch.
REQ-015 epoch_cnt  output  EPOCH_W  completed epochs.
REQ-016 param_init  output  1  core loads initial weights/biases this cycle.
REQ-017 train_done  output  1  sticky training-complete flag.

Function
REQ-018 FSM states SHALL be IDLE, INIT, RUN, RD, VLD, DONE.
REQ-019 IDLE: select_initial=1 -> INIT; else din=1 -> RUN; else stay.
REQ-020 INIT: param_init=1 for exactly that cycle; next state RUN if din=1, else IDLE.
REQ-021 RUN: sample_req=1 and din=1 -> RD; sample_req with din=0 SHALL be dropped, state unchanged.
REQ-022 RD: rd_en=1, rd_addr = current sample index; next state VLD (read latency fixed at 1).
REQ-023 VLD: sample_valid=1; sample_last=1 iff index = NUM_SAMPLES-1; next state RUN, or DONE per REQ-026.
REQ-024 Index SHALL advance on the RD->VLD edge; at NUM_SAMPLES-1 it wraps to 0 and epoch_cnt increments by 1 in the same cycle.
REQ-025 sample_req in RD, VLD, INIT, IDLE or DONE SHALL be ignored (single outstanding read, no queuing).
REQ-026 Wrap with epoch_cnt becoming NUM_EPOCHS (EPOCH_LIMIT_EN only) -> DONE; train_done=1 from the next cycle.
REQ-027 DONE: terminal; rd_en, sample_valid, param_init = 0; exit only via res.
REQ-028 rd_addr SHALL hold its value outside RD (no glitching); sample_last = 0 whenever sample_valid = 0.
REQ-029 select_initial=1 while in RUN SHALL return the FSM to INIT with index and epoch_cnt cleared.

Reset
REQ-030 res=1 at a clock edge SHALL force state IDLE, index 0, rd_addr 0, epoch_cnt 0, rd_en 0, sample_valid 0, sample_last 0, param_init 0, train_done 0.
REQ-031 Reset mid-read (RD or VLD) SHALL abandon the read; no sample_valid pulse after the reset edge.

Configuration
REQ-032 Macro EPOCH_LIMIT_EN defined: stop after NUM_EPOCHS per REQ-026.
REQ-033 Macro undefined: DONE unreachable, train_done tied 0, epoch_cnt wraps modulo 2**EPOCH_W, sequencing runs indefinitely.

Structure
REQ-034 Package ann_seq_pkg SHALL hold the FSM state encoding and default ADDR_W, EPOCH_W, read-latency constant.
REQ-035 Sub-module wrap_counter (parameterised modulus, enable, wrap pulse out) SHALL implement the sample index.

Verification
REQ-036 res 1->0 with select_initial high next cycle -> param_init one pulse, FSM in RUN, rd_en=0.
REQ-037 NUM_SAMPLES=4, four sample_req pulses spaced 4 cycles -> rd_addr 0,1,2,3; sample_valid each 1 cycle after rd_en; sample_last only on addr 3; epoch_cnt 0->1.
REQ-038 sample_req on consecutive cycles (RD then VLD) -> exactly one rd_en; second request dropped.
REQ-039 EPOCH_LIMIT_EN, NUM_SAMPLES=4, NUM_EPOCHS=3, 12 requests -> train_done=1 after 12th valid, epoch_cnt=3; 13th request produces no rd_en.
REQ-040 res asserted during RD -> no sample_valid afterwards; all outputs at reset values next cycle.
REQ-041 din=0 in RUN with sample_req -> no rd_en, rd_addr unchanged; din=1 plus sample_req -> read resumes at same address.
